// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter: fetch and load/store share one RAM port.
// Latency: grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: a losing requester holds its request; fetch starves at most MAX_STALL cycles.
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Stall counter is 4 bits wide, so the limit is truncated to that width.
  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  // Consecutive cycles the pending fetch has lost to the data port.
  logic [3:0] stall_cnt;

  // Owner tag of the read currently in flight at the RAM (one-hot, at most one set).
  logic       rd_owner_if;
  logic       rd_owner_d;

  // Arbitration decision before reset gating.
  logic       fetch_wins;
  logic       data_wins;

  // Fetch wins when alone, or when it has been starved for the full budget.
  always_comb begin
    fetch_wins = if_req && (!d_req || (stall_cnt == STALL_LIMIT));
    data_wins  = d_req && !fetch_wins;
  end

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    if_gnt = rst && fetch_wins;
    d_gnt  = rst && data_wins;
  end

  // RAM port is driven from whichever requester was granted this cycle.
  always_comb begin
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr : if_addr;
    mem_wdata = d_gnt ? d_wdata : '0;
  end

  // Starvation counter: counts lost fetch cycles, clears on grant or withdrawal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      stall_cnt <= 4'd0;
    end else if (stall_cnt < STALL_LIMIT) begin
      stall_cnt <= stall_cnt + 4'd1;
    end
  end

  // Record who owns the read issued this cycle; stores leave the tag empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_if <= 1'b0;
      rd_owner_d  <= 1'b0;
    end else begin
      rd_owner_if <= if_gnt;
      rd_owner_d  <= d_gnt && !d_we;
    end
  end

  // Steer the returning RAM data to its owner; the other side sees zero.
  always_comb begin
    if_rvalid = rd_owner_if;
    d_rvalid  = rd_owner_d;
    if_rdata  = rd_owner_if ? mem_rdata : '0;
    d_rdata   = rd_owner_d  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
// Expected values are hand-derived constants for each step.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_dat;
  logic [15:0] ram [256];

  int checks;
  int failures;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_STALL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_dat  = v;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = 8'h00;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 8'h00;
    d_wdata  = 16'h0000;
    pre_we   = 1'b0;
    pre_addr = 8'h00;
    pre_dat  = 16'h0000;

    // RAM contents loaded while the arbiter is held in reset.
    preload(8'h00, 16'hA000);
    preload(8'h01, 16'hA001);
    preload(8'h02, 16'hA002);
    preload(8'h03, 16'hA003);
    preload(8'h05, 16'h1234);
    @(negedge clk);
    pre_we = 1'b0;

    // Reset state with both requesters asserting.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    #1;
    chk("rst_if_gnt",    if_gnt,    0);
    chk("rst_d_gnt",     d_gnt,     0);
    chk("rst_mem_en",    mem_en,    0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid",  d_rvalid,  0);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_d_rdata",   d_rdata,   0);
    chk("rst_stall",     dut.stall_cnt, 0);

    // Lone fetch granted in the very first cycle out of reset.
    @(negedge clk);
    rst = 1'b1; if_req = 1'b1; if_addr = 8'h05; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("f1_if_gnt",   if_gnt,   1);
    chk("f1_d_gnt",    d_gnt,    0);
    chk("f1_mem_en",   mem_en,   1);
    chk("f1_mem_addr", mem_addr, 8'h05);
    chk("f1_mem_we",   mem_we,   0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("f1_if_rvalid", if_rvalid, 1);
    chk("f1_if_rdata",  if_rdata,  16'h1234);
    chk("f1_d_rvalid",  d_rvalid,  0);
    chk("f1_idle_en",   mem_en,    0);

    // Store 0xBEEF to 0x10, then load it back.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'hBEEF;
    #1;
    chk("st_d_gnt",     d_gnt,     1);
    chk("st_mem_we",    mem_we,    1);
    chk("st_mem_addr",  mem_addr,  8'h10);
    chk("st_mem_wdata", mem_wdata, 16'hBEEF);
    @(negedge clk);
    d_we = 1'b0; d_wdata = 16'h0000;
    #1;
    chk("ld_no_st_rvalid", d_rvalid, 0);
    chk("ld_d_rdata_idle", d_rdata,  0);
    chk("ld_d_gnt",        d_gnt,    1);
    chk("ld_mem_we",       mem_we,   0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("ld_d_rvalid",  d_rvalid,  1);
    chk("ld_d_rdata",   d_rdata,   16'hBEEF);
    chk("ld_if_rvalid", if_rvalid, 0);
    chk("ld_if_rdata",  if_rdata,  0);

    // Back-to-back fetches 0x00..0x03, responses pipelined in order.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'(i);
      #1;
      chk($sformatf("b2b_gnt%0d", i), if_gnt, 1);
      if (i > 0) begin
        chk($sformatf("b2b_rv%0d", i - 1), if_rvalid, 1);
        chk($sformatf("b2b_rd%0d", i - 1), if_rdata, 32'hA000 + 32'(i - 1));
      end
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("b2b_rv3", if_rvalid, 1);
    chk("b2b_rd3", if_rdata,  16'hA003);
    @(negedge clk);
    #1;
    chk("b2b_rv_end", if_rvalid, 0);

    // Contention: data wins three cycles, fetch wins the fourth, repeating.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      #1;
      chk($sformatf("ct_if%0d", k),  if_gnt, (k % 4 == 3) ? 1 : 0);
      chk($sformatf("ct_d%0d", k),   d_gnt,  (k % 4 == 3) ? 0 : 1);
      chk($sformatf("ct_both%0d", k), if_gnt & d_gnt, 0);
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;

    // Fetch withdrawn after two lost cycles: counter returns to zero.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h01; d_req = 1'b1;
      #1;
      chk($sformatf("wd_if%0d", k), if_gnt, 0);
    end
    @(negedge clk);
    #1;
    chk("wd_stall2", dut.stall_cnt, 2);
    if_req = 1'b0;
    #1;
    chk("wd_if_off", if_gnt, 0);
    @(negedge clk);
    #1;
    chk("wd_stall0", dut.stall_cnt, 0);
    chk("wd_no_gnt", if_gnt, 0);
    // A fresh fetch must again wait the full budget.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk($sformatf("re_if%0d", k), if_gnt, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;

    // Reset asserted inside the cycle after a fetch grant.
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h01;
    #1;
    chk("mr_if_gnt", if_gnt, 1);
    @(posedge clk);
    #2;
    rst = 1'b0; d_req = 1'b1; d_we = 1'b1;
    #1;
    chk("mr_if_rvalid", if_rvalid, 0);
    chk("mr_if_rdata",  if_rdata,  0);
    chk("mr_if_gnt0",   if_gnt,    0);
    chk("mr_d_gnt0",    d_gnt,     0);
    chk("mr_mem_en",    mem_en,    0);
    chk("mr_mem_we",    mem_we,    0);
    chk("mr_d_rvalid",  d_rvalid,  0);
    chk("mr_stall",     dut.stall_cnt, 0);
    @(negedge clk);
    #1;
    chk("mr_if_rvalid2", if_rvalid, 0);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("mr_rel_rvalid", if_rvalid, 0);
    @(negedge clk);
    #1;
    chk("mr_rel_rvalid2", if_rvalid, 0);
    chk("mr_rel_drvalid", d_rvalid,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
